// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key-expansion sequencer and datapath.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRESENT,
        EXPAND,
        FIN
    } state_t;

    localparam int         AES_NR        = 10;
    localparam logic [2:0] STEP_SUB_LAST = 3'd3;
    localparam logic [2:0] STEP_RCON     = 3'd4;
    localparam logic [2:0] STEP_WB       = 3'd5;
    localparam logic [2:0] STEP_IDLE     = 3'd7;

endpackage

// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for the AES-128 key expansion: loads the key, steps the
// datapath through each round and hands every round key to the cipher.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int         NR       = AES_NR,
    parameter logic [2:0] CNT_IDLE = STEP_IDLE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       key_load,
    output logic [3:0] round,
    output logic [2:0] cnt,
    output logic       rk_valid,
    output logic [3:0] rk_idx,
    input  logic       rk_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= CNT_IDLE;
            round    <= 4'd0;
            rk_idx   <= 4'd0;
            key_load <= 1'b0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            key_load <= 1'b0;
            done     <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                cnt      <= CNT_IDLE;
                round    <= 4'd0;
                rk_idx   <= 4'd0;
                rk_valid <= 1'b0;
                busy     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        cnt <= CNT_IDLE;
                        if (start) begin
                            state    <= LOAD;
                            key_load <= 1'b1;
                            busy     <= 1'b1;
                            round    <= 4'd0;
                            rk_idx   <= 4'd0;
                        end
                    end
                    LOAD: begin
                        state    <= PRESENT;
                        rk_valid <= 1'b1;
                    end
                    PRESENT: begin
                        // cnt stays parked so the presented key cannot move
                        if (rk_ready) begin
                            rk_valid <= 1'b0;
                            if (rk_idx == LAST_IDX) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end else begin
                                state <= EXPAND;
                                cnt   <= 3'd0;
                                round <= rk_idx;
                            end
                        end
                    end
                    EXPAND: begin
                        if (cnt == STEP_WB) begin
                            state    <= PRESENT;
                            cnt      <= CNT_IDLE;
                            rk_valid <= 1'b1;
                            rk_idx   <= round + 4'd1;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        cnt      <= CNT_IDLE;
                        rk_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench: drives the sequencer against a behavioural key-expansion
// datapath and checks timing, handshake, abort and reset behaviour.
module tb_aes_key_sched_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       key_load;
    logic [3:0] round;
    logic [2:0] cnt;
    logic       rk_valid;
    logic [3:0] rk_idx;
    logic       rk_ready;
    logic       busy;
    logic       done;

    aes_key_sched_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .key_load (key_load),
        .round    (round),
        .cnt      (cnt),
        .rk_valid (rk_valid),
        .rk_idx   (rk_idx),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    localparam logic [127:0] KEY_IN = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] KEY_1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] KEY_4  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    localparam logic [127:0] KEY_10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        logic [7:0] e = 8'd254;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (e[i]) r = gmul(r, a);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < int'(r); i++) v = xt(v);
        return v;
    endfunction

    // behavioural datapath and event recorder
    int           cyc = 0;
    logic [127:0] dp_key = '0;
    logic [31:0]  tmp = '0;
    logic [127:0] got_key [16];
    int           hs_cyc [16];
    int           kl_cnt, kl_cyc, done_cnt, done_cyc;
    int           cnt_bad, unstable, stall_n, hold_left;
    logic         prev_valid = 1'b0;
    logic [3:0]   prev_idx = '0;
    logic [127:0] prev_key = '0;
    logic         rdy;

    assign rk_ready = rdy && !(hold_left > 0 && rk_valid && rk_idx == 4'd3);

    always @(posedge clk) begin
        logic [31:0] rw;
        logic [31:0] w0, w1, w2, w3;
        int c;
        if (key_load) begin kl_cnt++; kl_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (rk_valid && cnt != 3'd7) cnt_bad++;
        if (rk_valid && prev_valid && rk_idx == prev_idx && dp_key != prev_key)
            unstable++;
        if (rk_valid && rk_ready) begin
            got_key[rk_idx] = dp_key;
            hs_cyc[rk_idx]  = cyc;
        end
        if (hold_left > 0 && rk_valid && rk_idx == 4'd3) begin
            stall_n++;
            hold_left--;
        end
        prev_valid = rk_valid;
        prev_idx   = rk_idx;
        prev_key   = dp_key;
        rw = {dp_key[23:0], dp_key[31:24]};
        c  = int'(cnt);
        if (key_load) dp_key = KEY_IN;
        else if (cnt <= 3'd3) tmp[31-8*c -: 8] = sbox(rw[31-8*c -: 8]);
        else if (cnt == 3'd4) tmp[31:24] = tmp[31:24] ^ rcon(round);
        else if (cnt == 3'd5) begin
            w0 = dp_key[127:96] ^ tmp;
            w1 = dp_key[95:64] ^ w0;
            w2 = dp_key[63:32] ^ w1;
            w3 = dp_key[31:0] ^ w2;
            dp_key = {w0, w1, w2, w3};
        end
        cyc++;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int t0;

    task automatic clear_rec();
        for (int i = 0; i < 16; i++) begin
            got_key[i] = '0;
            hs_cyc[i]  = -1;
        end
        kl_cnt = 0; kl_cyc = -1; done_cnt = 0; done_cyc = -1;
        cnt_bad = 0; unstable = 0; stall_n = 0;
    endtask

    task automatic run_sched(input int p1, input int p2);
        clear_rec();
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 150 && done_cnt == 0; k++) begin
            start = (cyc - t0 == p1 || cyc - t0 == p2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_run(input string tag, input int stall);
        chk({tag, " kl_cnt"}, 128'(kl_cnt), 128'd1);
        chk({tag, " kl_cyc"}, 128'(kl_cyc - t0), 128'd1);
        chk({tag, " hs0"}, 128'(hs_cyc[0] - t0), 128'd2);
        chk({tag, " hs1"}, 128'(hs_cyc[1] - t0), 128'd9);
        chk({tag, " hs10"}, 128'(hs_cyc[10] - t0), 128'(72 + stall));
        chk({tag, " done_cyc"}, 128'(done_cyc - t0), 128'(73 + stall));
        chk({tag, " done_cnt"}, 128'(done_cnt), 128'd1);
        chk({tag, " key0"}, got_key[0], KEY_IN);
        chk({tag, " key1"}, got_key[1], KEY_1);
        chk({tag, " key4"}, got_key[4], KEY_4);
        chk({tag, " key10"}, got_key[10], KEY_10);
        chk({tag, " cnt_park"}, 128'(cnt_bad), 128'd0);
        chk({tag, " busy_end"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int seen;
        int found;
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; rdy = 1'b1; hold_left = 0;
        clear_rec();
        repeat (3) @(posedge clk);
        #1;
        chk("rst cnt", 128'(cnt), 128'd7);
        chk("rst busy", 128'(busy), 128'd0);
        start = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy || key_load || rk_valid || done || cnt != 3'd7) seen++;
        end
        chk("idle activity", 128'(seen), 128'd0);
        chk("idle rk_idx", 128'(rk_idx), 128'd0);
        chk("idle round", 128'(round), 128'd0);

        run_sched(-1, -1);
        check_run("run", 0);

        hold_left = 5;
        run_sched(-1, -1);
        check_run("stall", 5);
        chk("stall cycles", 128'(stall_n), 128'd5);
        chk("stall hs3", 128'(hs_cyc[3] - t0), 128'd28);
        chk("stall hs4", 128'(hs_cyc[4] - t0), 128'd35);
        chk("stall key stable", 128'(unstable), 128'd0);
        hold_left = 0;

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start+abort busy", 128'(busy), 128'd0);
        chk("start+abort kl", 128'(key_load), 128'd0);

        clear_rec();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 120 && found == 0; k++) begin
            if (cnt == 3'd4 && round == 4'd6) found = 1;
            else begin @(posedge clk); #1; end
        end
        chk("abort reach", 128'(found), 128'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort cnt", 128'(cnt), 128'd7);
        chk("abort rk_valid", 128'(rk_valid), 128'd0);
        chk("abort busy", 128'(busy), 128'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort no done", 128'(done_cnt), 128'd0);
        run_sched(-1, -1);
        check_run("post abort", 0);

        run_sched(4, 73);
        check_run("start pulses", 0);

        clear_rec();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 120 && found == 0; k++) begin
            if (cnt == 3'd2 && round == 4'd2) found = 1;
            else begin @(posedge clk); #1; end
        end
        chk("arst reach", 128'(found), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst cnt", 128'(cnt), 128'd7);
        chk("arst round", 128'(round), 128'd0);
        chk("arst busy", 128'(busy), 128'd0);
        chk("arst rk_valid", 128'(rk_valid), 128'd0);
        chk("arst rk_idx", 128'(rk_idx), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_sched(-1, -1);
        check_run("post arst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
